uart_tx_cfg: RTL and testbench

Parametrised UART transmitter and next generation of the fixed 8N1 transmitter. Serialises one word per request, LSB first, with a configurable data width, optional odd/even parity and 1 or 2 stop bits. Adds a ready/valid request handshake, a synchronous reset and a frame-count output. It sits between the command/response logic and the board TX pin; one instance per serial channel.

---
 rtl/uart_tx_cfg.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, optional parity, 1 or 2 stop bits.
// Ready/valid request side, registered serial line, frame counter.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Word,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Done,
    output logic [15:0]          o_Frame_Count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_bit, par_bit_n;
    logic                 serial, serial_n;
    logic                 active, active_n;
    logic                 done, done_n;
    logic [15:0]          frame_cnt, frame_cnt_n;
    logic                 bit_end;
    logic                 accept;

    assign o_Tx_Ready    = (state == IDLE) && !i_Reset;
    assign o_Tx_Active   = active;
    assign o_Tx_Serial   = serial;
    assign o_Tx_Done     = done;
    assign o_Frame_Count = frame_cnt;

    assign accept  = i_Tx_DV && o_Tx_Ready;
    assign bit_end = (clk_cnt == CNT_LAST);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            serial    <= 1'b1;
            active    <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            clk_cnt   <= clk_cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            par_bit   <= par_bit_n;
            serial    <= serial_n;
            active    <= active_n;
            done      <= done_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    // The line register takes the level of the current state, so it trails
    // the state by one clock: accept at edge k drives the start bit at k+1.
    always_comb begin
        state_n     = state;
        clk_cnt_n   = clk_cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        par_bit_n   = par_bit;
        serial_n    = 1'b1;
        active_n    = active;
        done_n      = 1'b0;
        frame_cnt_n = frame_cnt;

        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                bit_idx_n = '0;
                if (accept) begin
                    shift_n   = i_Tx_Word;
                    par_bit_n = (PARITY_MODE == 1) ? ~(^i_Tx_Word)
                                                   : (^i_Tx_Word);
                    active_n  = 1'b1;
                    state_n   = START;
                end
            end
            START: begin
                serial_n = 1'b0;
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                serial_n = shift[0];
                if (bit_end) begin
                    clk_cnt_n = '0;
                    shift_n   = shift >> 1;
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                serial_n = par_bit;
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = STOP;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_idx_n   = '0;
                        active_n    = 1'b0;
                        done_n      = 1'b1;
                        frame_cnt_n = frame_cnt + 16'd1;
                        state_n     = CLEANUP;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            CLEANUP: begin
                state_n = IDLE;
            end
            default: begin
                active_n = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four configurations checked cycle by cycle
// against hand-written line patterns (time order, one char per bit period).
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic [3:0] rs;
    logic [3:0] dv;
    logic [7:0] wd [0:3];
    wire  [3:0] rdy;
    wire  [3:0] act;
    wire  [3:0] ser;
    wire  [3:0] dn;
    wire [15:0] fc [0:3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
        .i_Clock(clk), .i_Reset(rs[0]), .i_Tx_DV(dv[0]), .i_Tx_Word(wd[0]),
        .o_Tx_Ready(rdy[0]), .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]),
        .o_Tx_Done(dn[0]), .o_Frame_Count(fc[0]));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_e (
        .i_Clock(clk), .i_Reset(rs[1]), .i_Tx_DV(dv[1]), .i_Tx_Word(wd[1]),
        .o_Tx_Ready(rdy[1]), .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]),
        .o_Tx_Done(dn[1]), .o_Frame_Count(fc[1]));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_o (
        .i_Clock(clk), .i_Reset(rs[2]), .i_Tx_DV(dv[2]), .i_Tx_Word(wd[2]),
        .o_Tx_Ready(rdy[2]), .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]),
        .o_Tx_Done(dn[2]), .o_Frame_Count(fc[2]));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(2)) u_f (
        .i_Clock(clk), .i_Reset(rs[3]), .i_Tx_DV(dv[3]), .i_Tx_Word(wd[3][4:0]),
        .o_Tx_Ready(rdy[3]), .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]),
        .o_Tx_Done(dn[3]), .o_Frame_Count(fc[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the instance idle. Sends w and checks every
    // clock of the line against exp. With hold set, i_Tx_DV stays high.
    task automatic frame(input int sel, input logic [7:0] w, input string exp,
                         input bit hold);
        int   n;
        logic eb;
        n = exp.len() * 4;
        wd[sel] = w;
        dv[sel] = 1'b1;
        chk($sformatf("rdy_pre%0d", sel), {31'd0, rdy[sel]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) dv[sel] = 1'b0;
        wd[sel] = ~w;
        chk($sformatf("acc%0d", sel), {29'd0, ser[sel], act[sel], rdy[sel]}, 32'b110);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            eb = (exp[i / 4] == "1");
            chk($sformatf("line%0d_%s_c%0d", sel, exp, i),
                {29'd0, ser[sel], dn[sel], act[sel]},
                {29'd0, eb, (i == n - 1), (i < n - 1)});
        end
        @(negedge clk);
        chk($sformatf("end%0d", sel),
            {28'd0, ser[sel], dn[sel], rdy[sel], act[sel]}, 32'b1010);
    endtask

    initial begin
        rs = 4'hF;
        dv = 4'h0;
        for (int i = 0; i < 4; i++) wd[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_rdy", {28'd0, rdy}, 32'h0);
        chk("rst_ser", {28'd0, ser}, 32'hF);
        chk("rst_act", {28'd0, act}, 32'h0);
        chk("rst_done", {28'd0, dn}, 32'h0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_cnt%0d", i), {16'd0, fc[i]}, 32'h0);
        rs = 4'h0;
        #1;
        chk("rdy_after_rst", {28'd0, rdy}, 32'hF);
        @(negedge clk);

        frame(0, 8'hA5, "0101001011", 1'b0);
        chk("cnt_a1", {16'd0, fc[0]}, 32'd1);

        frame(1, 8'h07, "01110000011", 1'b0);
        chk("cnt_e1", {16'd0, fc[1]}, 32'd1);
        frame(2, 8'h07, "01110000001", 1'b0);
        chk("cnt_o1", {16'd0, fc[2]}, 32'd1);

        frame(3, 8'h1F, "01111111", 1'b0);
        chk("cnt_f1", {16'd0, fc[3]}, 32'd1);

        frame(0, 8'h3C, "0001111001", 1'b1);
        frame(0, 8'hC3, "0110000111", 1'b1);
        frame(0, 8'h81, "0100000011", 1'b1);
        dv[0] = 1'b0;
        chk("cnt_hold", {16'd0, fc[0]}, 32'd4);

        @(negedge clk);
        rs[0] = 1'b1;
        dv[0] = 1'b1;
        wd[0] = 8'h55;
        @(negedge clk);
        chk("rstdv_rdy", {31'd0, rdy[0]}, 32'd0);
        chk("rstdv_act", {31'd0, act[0]}, 32'd0);
        chk("rstdv_cnt", {16'd0, fc[0]}, 32'd0);
        rs[0] = 1'b0;
        dv[0] = 1'b0;
        @(negedge clk);
        chk("rstdv_idle", {29'd0, ser[0], act[0], rdy[0]}, 32'b101);

        wd[0] = 8'h00;
        dv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv[0] = 1'b0;
        repeat (16) @(negedge clk);
        chk("abort_pre", {30'd0, ser[0], act[0]}, 32'b01);
        rs[0] = 1'b1;
        @(negedge clk);
        rs[0] = 1'b0;
        chk("abort_line", {29'd0, ser[0], act[0], dn[0]}, 32'b100);
        chk("abort_cnt", {16'd0, fc[0]}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet_c%0d", i),
                {28'd0, ser[0], dn[0], act[0], rdy[0]}, 32'b1001);
        end
        frame(0, 8'h00, "0000000001", 1'b0);
        chk("cnt_after_abort", {16'd0, fc[0]}, 32'd1);

        force u_a.frame_cnt = 16'hFFFF;
        #1;
        release u_a.frame_cnt;
        #1;
        chk("cnt_forced", {16'd0, fc[0]}, 32'h0000FFFF);
        @(negedge clk);
        frame(0, 8'h5A, "0010110101", 1'b0);
        chk("cnt_wrap", {16'd0, fc[0]}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
